// File: rtl/mantissa_aligner.sv
// Float32 adder pre-add alignment: picks the larger exponent and right-shifts the
// smaller mantissa STEP bits per cycle, accumulating guard/round/sticky.
module mantissa_aligner #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a_exp,
  input  logic [23:0] a_mant,
  input  logic [7:0]  b_exp,
  input  logic [23:0] b_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_out,
  output logic [23:0] big_mant,
  output logic [23:0] small_mant,
  output logic [2:0]  grs,
  output logic        swapped
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);
  localparam logic [4:0] MAX_SH = 5'd27;

  state_t      state_q, state_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] big_q, big_d;
  logic [26:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        swap_q, swap_d;

  logic [4:0]  step_s;
  logic [26:0] shifted;
  logic        sticky;
  logic        b_wins;
  logic [7:0]  diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      big_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      swap_q  <= swap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    big_d   = big_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    swap_d  = swap_q;

    step_s  = (cnt_q > STEP_W) ? STEP_W : cnt_q;
    shifted = sr_q >> step_s;
    // Bit landing in position 0 and every bit shifted past it fold into sticky.
    sticky  = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (i <= 32'(step_s)) sticky = sticky | sr_q[i];
    end

    b_wins = (b_exp > a_exp);
    diff   = b_wins ? (b_exp - a_exp) : (a_exp - b_exp);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          swap_d = b_wins;
          exp_d  = b_wins ? b_exp : a_exp;
          big_d  = b_wins ? b_mant : a_mant;
          sr_d   = {(b_wins ? a_mant : b_mant), 3'b000};
          cnt_d  = (diff > 8'(MAX_SH)) ? MAX_SH : diff[4:0];
          state_d = (cnt_d == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {shifted[26:1], sticky};
        cnt_d = cnt_q - step_s;
        if (cnt_d == 5'd0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign exp_out    = exp_q;
  assign big_mant   = big_q;
  assign small_mant = sr_q[26:3];
  assign grs        = sr_q[2:0];
  assign swapped    = swap_q;

endmodule

// File: tb/tb_mantissa_aligner.sv
// Self-checking bench for mantissa_aligner: directed cases plus randomized
// operand pairs compared against an arithmetic alignment model.
module tb_mantissa_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_exp = '0;
  logic [23:0] a_mant = '0;
  logic [7:0]  b_exp = '0;
  logic [23:0] b_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  exp_out;
  logic [23:0] big_mant;
  logic [23:0] small_mant;
  logic [2:0]  grs;
  logic        swapped;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  mantissa_aligner #(.STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_exp      (a_exp),
    .a_mant     (a_mant),
    .b_exp      (b_exp),
    .b_mant     (b_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_out    (exp_out),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .grs        (grs),
    .swapped    (swapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Alignment in one step: full shift, then OR everything lost into bit 0.
  task automatic model(input int ae, input int am, input int be, input int bm,
                       output int e_exp, output int e_big, output int e_small,
                       output int e_grs, output int e_swap, output int e_lat);
    longint v, r;
    int d;
    e_swap = (be > ae) ? 1 : 0;
    e_exp  = e_swap ? be : ae;
    e_big  = e_swap ? bm : am;
    d      = e_swap ? be - ae : ae - be;
    if (d > 27) d = 27;
    v = longint'(e_swap ? am : bm) * 8;
    r = v >> d;
    if ((v % (longint'(1) << d)) != 0) r = r | 1;
    e_small = int'(r >> 3);
    e_grs   = int'(r % 8);
    e_lat   = 1 + (d + 3) / 4;
  endtask

  task automatic check_outs(input string tag, input int e_exp, input int e_big,
                            input int e_small, input int e_grs, input int e_swap);
    chk({tag, ".exp"},   32'(exp_out),    32'(e_exp));
    chk({tag, ".big"},   32'(big_mant),   32'(e_big));
    chk({tag, ".small"}, 32'(small_mant), 32'(e_small));
    chk({tag, ".grs"},   32'(grs),        32'(e_grs));
    chk({tag, ".swap"},  32'(swapped),    32'(e_swap));
  endtask

  // Called #1 after a clock edge while the DUT is idle.
  task automatic do_op(input string tag, input int ae, input int am, input int be,
                       input int bm, input int hold);
    int e_exp, e_big, e_small, e_grs, e_swap, e_lat, cyc;
    model(ae, am, be, bm, e_exp, e_big, e_small, e_grs, e_swap, e_lat);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a_exp = 8'(ae); a_mant = 24'(am); b_exp = 8'(be); b_mant = 24'(bm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      chk({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
      a_exp = 8'($urandom); a_mant = 24'($urandom); b_exp = 8'($urandom); b_mant = 24'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(e_lat));
    check_outs(tag, e_exp, e_big, e_small, e_grs, e_swap);
    for (int h = 0; h < hold; h++) begin
      a_exp = 8'($urandom); a_mant = 24'($urandom); b_exp = 8'($urandom); b_mant = 24'($urandom);
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      check_outs({tag, ".hold"}, e_exp, e_big, e_small, e_grs, e_swap);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int ae, be, am, bm;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    check_outs("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    do_op("T1", 130, 'hC00000, 128, 'h800003, 0);
    do_op("T2", 100, 'h800001, 110, 'h900000, 0);
    do_op("T3", 200, 'hABCDEF, 10, 'h800000, 0);
    do_op("T4", 127, 'h800000, 127, 'hFFFFFF, 0);
    do_op("T5a", 130, 'hC00000, 128, 'h800003, 5);
    do_op("T5b", 90, 'h812345, 95, 'hF00000, 0);
    do_op("zero", 140, 'h800000, 120, 'h000000, 0);
    do_op("sat", 5, 'h000001, 250, 'h800000, 0);

    // Reset mid-shift abandons the transaction.
    a_exp = 8'd200; a_mant = 24'hABCDEF; b_exp = 8'd10; b_mant = 24'h800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("T6.out_valid", 32'(out_valid), 32'd0);
    chk("T6.in_ready", 32'(in_ready), 32'd1);
    check_outs("T6", 0, 0, 0, 0, 0);
    do_op("T6.after", 130, 'hC00000, 128, 'h800003, 0);

    for (int n = 0; n < 150; n++) begin
      ae = int'($urandom_range(0, 255));
      be = (ae + int'($urandom_range(0, 70)) - 35) & 255;
      if ($urandom_range(0, 9) == 0) be = ae;
      am = int'($urandom & 32'h7FFFFF) | (($urandom_range(0, 7) != 0) ? 'h800000 : 0);
      bm = int'($urandom & 32'h7FFFFF) | (($urandom_range(0, 7) != 0) ? 'h800000 : 0);
      if ($urandom_range(0, 19) == 0) bm = 0;
      do_op("rand", ae, am, be, bm, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
